// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM state type and BCD digit width for the stopwatch core
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam int DIGIT_W = 4;
endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: one up/down BCD digit wrapping at BASE; ports: clk, rst_n, en (tick), dir (1=down), cnt_in (lower digits terminal), load/load_val (saturating preset), digit, terminal
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int BASE = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               dir,
  input  logic               cnt_in,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] digit,
  output logic               terminal
);
  localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(BASE - 1);
  logic [DIGIT_W-1:0] digit_q, digit_d;
  always_comb begin
    digit_d = load ? ((load_val > TOP) ? TOP : load_val) :
              !(en && cnt_in) ? digit_q :
              dir ? ((digit_q == '0) ? TOP : digit_q - 1'b1) :
                    ((digit_q == TOP) ? '0 : digit_q + 1'b1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digit_q <= '0;
    else digit_q <= digit_d;
  end
  assign digit    = digit_q;
  assign terminal = dir ? (digit_q == '0) : (digit_q == TOP);
endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: run/pause/lap up/down BCD timer; ports: clk, rst_n, start_stop/lap/clear/load pulses, mode_down, load_value -> count_bcd, display_bcd, running, lap_active, tick, overflow, done; STOPWATCH_AUTO_RELOAD_EN enables down-count auto reload
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int          CLK_FREQ_HZ = 100_000_000,
  parameter int          TICK_HZ     = 1,
  parameter int          NUM_DIGITS  = 4,
  parameter logic [31:0] DIGIT_BASES = 32'h0000_6A6A
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_stop,
  input  logic                          lap,
  input  logic                          clear,
  input  logic                          mode_down,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_value,
  output logic [DIGIT_W*NUM_DIGITS-1:0] count_bcd,
  output logic [DIGIT_W*NUM_DIGITS-1:0] display_bcd,
  output logic                          running,
  output logic                          lap_active,
  output logic                          tick,
  output logic                          overflow,
  output logic                          done
);
  localparam int DIV  = CLK_FREQ_HZ / TICK_HZ;
  localparam int DIVW = $clog2(DIV);
  localparam int DW   = DIGIT_W * NUM_DIGITS;
  state_t state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic down_q, down_d, lap_q, lap_d, done_q, done_d, running_q, overflow_q;
  logic [DW-1:0] count, snap_q, snap_d, display_q, reload_val;
  logic [NUM_DIGITS-1:0] term;
  logic [NUM_DIGITS:0] carry;
  logic ld, ss, lp, hit_zero, reload, start_zero;
  assign tick = (state_q == RUN) && (div_q == DIVW'(DIV - 1));
  // accepted events in priority order: clear > load > start_stop > lap
  assign ld = !clear && load && (state_q == IDLE || state_q == PAUSE);
  assign ss = !clear && !ld && start_stop;
  assign lp = !clear && !ld && !ss && lap && (state_q == RUN || state_q == PAUSE);
  // a down step lands on zero only from a count of exactly one
  assign hit_zero = tick && !clear && down_q && (count == DW'(1));
`ifdef STOPWATCH_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
  logic [DW-1:0] reload_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reload_q <= '0;
    else if (ld) reload_q <= load_value;
  end
  assign reload     = hit_zero;
  assign reload_val = reload_q;
`else
  localparam bit AUTO = 1'b0;
  assign reload     = 1'b0;
  assign reload_val = '0;
`endif
  assign start_zero = mode_down && (count == '0) && !AUTO;
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_counter #(.BASE(int'(DIGIT_BASES[DIGIT_W*i +: DIGIT_W]))) u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (tick),
      .dir      (down_q),
      .cnt_in   (carry[i]),
      .load     (clear || ld || reload),
      .load_val (clear ? '0 : reload ? reload_val[DIGIT_W*i +: DIGIT_W] : load_value[DIGIT_W*i +: DIGIT_W]),
      .digit    (count[DIGIT_W*i +: DIGIT_W]),
      .terminal (term[i])
    );
    assign carry[i+1] = carry[i] && term[i];
  end
  always_comb begin
    state_d = state_q;
    down_d  = down_q;
    div_d   = (state_q == RUN) ? (tick ? '0 : div_q + 1'b1) : div_q;
    done_d  = AUTO ? 1'b0 : done_q;
    lap_d   = lp ? !lap_q : lap_q;
    snap_d  = (lp && !lap_q) ? count : snap_q;
    if (clear) begin
      state_d = IDLE;
      div_d   = '0;
      done_d  = 1'b0;
      lap_d   = 1'b0;
    end else if (hit_zero) begin
      done_d  = 1'b1;
      state_d = AUTO ? state_q : DONE;
    end else if (ss) begin
      unique case (state_q)
        IDLE: begin
          down_d  = mode_down;
          div_d   = '0;
          state_d = start_zero ? DONE : RUN;
          done_d  = start_zero;
        end
        RUN:   state_d = PAUSE;
        PAUSE: state_d = RUN;
        DONE: begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      down_q     <= 1'b0;
      lap_q      <= 1'b0;
      done_q     <= 1'b0;
      snap_q     <= '0;
      display_q  <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      down_q     <= down_d;
      lap_q      <= lap_d;
      done_q     <= done_d;
      snap_q     <= snap_d;
      display_q  <= lap_d ? snap_d : count;
      running_q  <= (state_d == RUN);
      overflow_q <= tick && !clear && !down_q && carry[NUM_DIGITS];
    end
  end
  assign count_bcd   = count;
  assign display_bcd = display_q;
  assign running     = running_q;
  assign lap_active  = lap_q;
  assign overflow    = overflow_q;
  assign done        = done_q;
endmodule
